mem_arbiter: RTL and testbench

- Two-port to one-port memory arbiter for the RV32I core.
- Shares the single physical memory interface (mem_read/mem_write/mem_resp handshake) between an instruction-fetch requester (I, read-only) and a data requester (D, read/write with byte enables).
- Sits between the control/datapath and physical memory, so fetch and load/store engines can be split and later fronted by separate caches.
- Grants one transaction at a time and holds the grant until mem_resp.

---
 rtl/mem_arbiter_if.sv | 49 ++++
 rtl/mem_arbiter.sv | 106 ++++++++++
 tb/tb_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the instruction port, the data port and the
// shared physical memory port of the memory arbiter.
// slave  : the arbiter's view (requests and memory returns come in).
// master : the environment's view (requesters plus physical memory).
interface mem_arbiter_if #(
  parameter int WIDTH = 32
);
  // instruction fetch port (read-only)
  logic             i_read;
  logic [WIDTH-1:0] i_address;
  logic [WIDTH-1:0] i_rdata;
  logic             i_resp;
  // data port (read/write with byte enables)
  logic             d_read;
  logic             d_write;
  logic [3:0]       d_byte_enable;
  logic [WIDTH-1:0] d_address;
  logic [WIDTH-1:0] d_wdata;
  logic [WIDTH-1:0] d_rdata;
  logic             d_resp;
  // shared physical memory port
  logic             mem_read;
  logic             mem_write;
  logic [3:0]       mem_byte_enable;
  logic [WIDTH-1:0] mem_address;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_resp;
  // arbiter status
  logic             busy;

  modport slave (
    input  i_read, i_address,
    input  d_read, d_write, d_byte_enable, d_address, d_wdata,
    input  mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output busy
  );

  modport master (
    output i_read, i_address,
    output d_read, d_write, d_byte_enable, d_address, d_wdata,
    output mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one physical memory port between the instruction
// fetch requester (I) and the data requester (D). One transaction at a
// time; the grant is held until mem_resp, then one IDLE bubble follows.
// Request fields are passed through live, never latched.
// Optional macro ARB_RR_EN: round-robin between I and D on contention
// (rr_last pointer); without it, D_FIRST fixes the contention winner.
module mem_arbiter #(
  parameter int WIDTH   = 32,
  parameter bit D_FIRST = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  localparam logic [WIDTH-1:0] ZERO = '0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state;
  logic   i_req;
  logic   d_req;
  logic   grant_d;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

`ifdef ARB_RR_EN
  // rr_last: 1 = D was granted last, 0 = I was granted last
  logic rr_last;

  // contention goes to the port that did not win last time
  assign grant_d = d_req & (~i_req | ~rr_last);

  // remember the winner of every IDLE->SERVE transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= 1'b0;
    end else if (state == IDLE && (i_req || d_req)) begin
      rr_last <= grant_d;
    end
  end
`else
  // contention goes to the fixed-priority port
  assign grant_d = d_req & (~i_req | D_FIRST);
`endif

  // grant FSM: pick a port in IDLE, hold it until mem_resp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) state <= grant_d ? SERVE_D : SERVE_I;
        end
        SERVE_I, SERVE_D: begin
          if (bus.mem_resp) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // memory strobes and completion pulses follow the granted port
  always_comb begin
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_byte_enable = 4'h0;
    bus.mem_address     = ZERO;
    bus.mem_wdata       = ZERO;
    bus.i_resp          = 1'b0;
    bus.d_resp          = 1'b0;
    // read data mirrors memory; only the resp pulses are grant-gated
    bus.i_rdata         = bus.mem_rdata;
    bus.d_rdata         = bus.mem_rdata;
    bus.busy            = (state != IDLE);
    case (state)
      SERVE_I: begin
        bus.mem_read        = 1'b1;
        bus.mem_address     = bus.i_address;
        bus.mem_byte_enable = 4'hF;
        bus.i_resp          = bus.mem_resp;
      end
      SERVE_D: begin
        bus.mem_address = bus.d_address;
        bus.d_resp      = bus.mem_resp;
        // read+write together: the write is performed, the read dropped
        if (bus.d_write) begin
          bus.mem_write       = 1'b1;
          bus.mem_wdata       = bus.d_wdata;
          bus.mem_byte_enable = bus.d_byte_enable;
        end else begin
          bus.mem_read        = 1'b1;
          bus.mem_byte_enable = 4'hF;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed plus randomized checks of mem_arbiter against
// a transaction-level model (who wins, what the memory port must show,
// when each resp pulses). Builds with or without ARB_RR_EN.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int W  = 32;
  localparam bit DF = 1'b1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mem_arbiter_if #(.WIDTH(W)) bus();

  mem_arbiter #(.WIDTH(W), .D_FIRST(DF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // requester and memory stimulus
  logic         ir    = 1'b0;
  logic         dr    = 1'b0;
  logic         dw    = 1'b0;
  logic         mresp = 1'b0;
  logic [3:0]   dbe   = 4'h0;
  logic [W-1:0] ia    = '0;
  logic [W-1:0] da    = '0;
  logic [W-1:0] dwd   = '0;
  logic [W-1:0] mrd   = '0;

  assign bus.i_read        = ir;
  assign bus.i_address     = ia;
  assign bus.d_read        = dr;
  assign bus.d_write       = dw;
  assign bus.d_byte_enable = dbe;
  assign bus.d_address     = da;
  assign bus.d_wdata       = dwd;
  assign bus.mem_resp      = mresp;
  assign bus.mem_rdata     = mrd;

  int vectors     = 0;
  int miscompares = 0;

`ifdef ARB_RR_EN
  bit m_rr = 1'b0;  // model: 1 = D granted last
`endif

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // model arbitration decision for the requests currently presented (1 = D)
  function automatic bit pick();
    bit want_i;
    bit want_d;
    bit g;
    want_i = ir;
    want_d = dr | dw;
    if (want_d && !want_i)      g = 1'b1;
    else if (want_i && !want_d) g = 1'b0;
    else begin
`ifdef ARB_RR_EN
      g = ~m_rr;
`else
      g = DF;
`endif
    end
`ifdef ARB_RR_EN
    m_rr = g;
`endif
    return g;
  endfunction

  // everything on the memory side must be quiet, no resp forwarded
  task automatic chk_idle(input string tag);
    @(negedge clk);
    chk({tag, ".busy"},      32'(bus.busy), 0);
    chk({tag, ".mem_read"},  32'(bus.mem_read), 0);
    chk({tag, ".mem_write"}, 32'(bus.mem_write), 0);
    chk({tag, ".mem_be"},    32'(bus.mem_byte_enable), 0);
    chk({tag, ".mem_addr"},  bus.mem_address, 0);
    chk({tag, ".mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, ".i_resp"},    32'(bus.i_resp), 0);
    chk({tag, ".d_resp"},    32'(bus.d_resp), 0);
  endtask

  // one granted transaction: starts in the first SERVE cycle, ends one
  // cycle after mem_resp (bubble cycle, posedge+1)
  task automatic do_grant(input bit g, input int delay, input logic [W-1:0] rd);
    bit           wr;
    bit           last;
    logic [W-1:0] ea;
    wr = g & dw;
    ea = g ? da : ia;
    for (int k = 0; k <= delay; k++) begin
      last  = (k == delay);
      mresp = last;
      if (last) mrd = rd;
      @(negedge clk);
      chk("srv.busy",      32'(bus.busy), 1);
      chk("srv.mem_read",  32'(bus.mem_read), 32'(!wr));
      chk("srv.mem_write", 32'(bus.mem_write), 32'(wr));
      chk("srv.mem_addr",  bus.mem_address, ea);
      chk("srv.mem_be",    32'(bus.mem_byte_enable), wr ? 32'(dbe) : 'hF);
      chk("srv.mem_wdata", bus.mem_wdata, wr ? dwd : 0);
      chk("srv.i_resp",    32'(bus.i_resp), 32'(!g && last));
      chk("srv.d_resp",    32'(bus.d_resp), 32'(g && last));
      if (last) chk(g ? "srv.d_rdata" : "srv.i_rdata", g ? bus.d_rdata : bus.i_rdata, rd);
      tick();
    end
    mresp = 1'b0;
  endtask

  task automatic new_i();
    ir = 1'b1;
    ia = $urandom & 32'h7FFF_FFFC;
  endtask

  task automatic new_d();
    dw  = 1'($urandom_range(0, 1));
    dr  = dw ? ($urandom_range(0, 3) == 0) : 1'b1;
    dbe = 4'($urandom);
    da  = $urandom | 32'h8000_0000;
    dwd = $urandom;
  endtask

  task automatic drop(input bit g);
    if (g) begin
      dr = 1'b0;
      dw = 1'b0;
    end else begin
      ir = 1'b0;
    end
  endtask

  // serve everything pending; with refill the served port re-requests
  // until max_grants grants have been issued
  task automatic run_pending(input int max_grants, input bit refill);
    int n;
    bit g;
    n = 0;
    while ((ir || dr || dw) && n < max_grants + 2) begin
      g = pick();
      chk_idle("idle");
      tick();
      do_grant(g, $urandom_range(0, 3), $urandom);
      n++;
      if (refill && n < max_grants) begin
        if (g) new_d();
        else   new_i();
      end else begin
        drop(g);
      end
      // stale resp during the bubble must be ignored
      mresp = ($urandom_range(0, 3) == 0);
    end
    chk_idle("idle_end");
    tick();
    mresp = 1'b0;
  endtask

  initial begin
    bit g;
    // reset state with requests already presented
    ir = 1'b1; ia = 32'h40; dw = 1'b1; da = 32'h80;
    #3;
    chk_idle("rst");
    tick();
    chk_idle("rst_hold");
    tick();
    ir = 1'b0; dw = 1'b0;
    rst_n = 1'b1;
    chk_idle("post_rst");
    tick();

    // asynchronous reset in the middle of a D write
    dw = 1'b1; da = 32'h200; dwd = 32'h1234_5678; dbe = 4'hF;
    g = pick();
    chk_idle("arst.idle");
    tick();
    @(negedge clk);
    chk("arst.mem_write_pre", 32'(bus.mem_write), 1);
    #1 rst_n = 1'b0; dw = 1'b0;
    #1;
    chk("arst.mem_write", 32'(bus.mem_write), 0);
    chk("arst.busy",      32'(bus.busy), 0);
`ifdef ARB_RR_EN
    m_rr = 1'b0;
`endif
    tick();
    rst_n = 1'b1;
    mresp = 1'b1;  // late resp from the aborted access
    @(negedge clk);
    chk("arst.d_resp", 32'(bus.d_resp), 0);
    chk("arst.busy2",  32'(bus.busy), 0);
    tick();
    mresp = 1'b0;
    chk_idle("arst.after");
    tick();

    // I only, memory answers on the fourth SERVE cycle
    ir = 1'b1; ia = 32'h0000_0060;
    g = pick();
    chk_idle("ionly.idle");
    tick();
    do_grant(g, 3, 32'h0000_0013);
    drop(g);
    chk_idle("ionly.bubble");
    tick();

    // D write with partial byte enables
    dw = 1'b1; da = 32'h100; dwd = 32'hDEAD_BEEF; dbe = 4'b0011;
    run_pending(1, 1'b0);

    // spurious mem_resp with nothing pending
    mresp = 1'b1;
    chk_idle("spur");
    tick();
    mresp = 1'b0;
    chk_idle("spur.after");
    tick();

    // request withdrawn before any edge sees it
    ir = 1'b1; ia = 32'h44;
    #2 ir = 1'b0;
    tick();
    chk_idle("withdrawn");
    tick();

    // contention, single request each
    ir = 1'b1; ia = 32'h0000_0700;
    dr = 1'b1; dw = 1'b0; da = 32'h8000_0900;
    run_pending(2, 1'b0);

    // read and write together: write wins
    dr = 1'b1; dw = 1'b1; da = 32'h8000_0040; dwd = 32'hCAFE_F00D; dbe = 4'b1100;
    run_pending(1, 1'b0);

    // continuous contention for six grants
    new_i();
    new_d();
    run_pending(6, 1'b1);

    // randomized rounds
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 1)) new_i();
      if ($urandom_range(0, 1)) new_d();
      if (!(ir || dr || dw)) begin
        mresp = 1'($urandom_range(0, 1));
        chk_idle("rnd.empty");
        tick();
        mresp = 1'b0;
      end else begin
        run_pending($urandom_range(1, 4), 1'($urandom_range(0, 1)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // the sequence is fixed-length; this only guards against a stuck run
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
